cacheline_adapter: RTL and testbench



---
 rtl/rv32i_types.sv | 18 +
 rtl/cacheline_adapter.sv | 145 ++++++++++++++
 tb/tb_cacheline_adapter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the cache-side memory bridge.
//   adapter_state_t  : cacheline_adapter controller states
//   CACHELINE_WIDTH  : default cache line width in bits
//   BMEM_WIDTH       : default burst-memory data width in bits
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    RESP
  } adapter_state_t;

  localparam int CACHELINE_WIDTH = 256;
  localparam int BMEM_WIDTH      = 64;

endpackage

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges the line-wide dfp port to the narrow burst
// memory (bmem). Read bursts are deserialised into one line, dirty lines are
// serialised into write bursts. The burst address is line-aligned.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   dfp_addr          request address (line offset bits ignored)
//   dfp_read/write    line requests, held until dfp_resp
//   dfp_wdata         line to write, beat k at [k*BUS_WIDTH +: BUS_WIDTH]
//   dfp_rdata         assembled read line
//   dfp_resp          one-cycle completion pulse
//   bmem_addr         aligned burst address (0 unless requesting/writing)
//   bmem_read         read burst request
//   bmem_write        write beat valid, bmem_wdata is the beat
//   bmem_ready        memory accepts the request or beat this cycle
//   bmem_rdata/rvalid read beat and its qualifier
//
// state   | meaning
// IDLE    | waiting for a dfp request
// RD_REQ  | read burst request presented, waiting for bmem_ready
// RD_DATA | collecting read beats into the line register
// WR      | presenting write beats, advancing on bmem_ready
// RESP    | one-cycle dfp_resp
module cacheline_adapter
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH = CACHELINE_WIDTH,
  parameter int BUS_WIDTH  = BMEM_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BUS_WIDTH-1:0]  bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [BUS_WIDTH-1:0]  bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int BEATS  = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  // Slot arrays are sized to the full counter range so indexing by cnt is
  // always in bounds, including the single-beat configuration.
  localparam int SLOTS  = 1 << CNT_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (LINE_WIDTH % BUS_WIDTH != 0) begin : g_width_check
    $error("cacheline_adapter: LINE_WIDTH must be a multiple of BUS_WIDTH");
  end

  adapter_state_t state, state_next;

  logic [CNT_W-1:0]                 cnt;
  logic [SLOTS-1:0][BUS_WIDTH-1:0]  rline;
  logic [SLOTS-1:0][BUS_WIDTH-1:0]  wline;
  logic [ADDR_WIDTH-1:0]            addr_q;
  logic [ADDR_WIDTH-1:0]            addr_aligned;
  logic                             last_beat;
  logic                             unused_addr_bits;

  assign addr_aligned     = {dfp_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
  assign unused_addr_bits = ^dfp_addr[OFFSET-1:0];
  assign last_beat        = (cnt == LAST_BEAT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dfp_write)     state_next = WR;
        else if (dfp_read) state_next = RD_REQ;
      end
      RD_REQ:  if (bmem_ready) state_next = RD_DATA;
      RD_DATA: if (bmem_rvalid && last_beat) state_next = RESP;
      WR:      if (bmem_ready && last_beat) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rline  <= '0;
      wline  <= '0;
      addr_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dfp_write) begin
            wline[BEATS-1:0] <= dfp_wdata;
            addr_q           <= addr_aligned;
          end else if (dfp_read) begin
            addr_q <= addr_aligned;
          end
        end
        RD_REQ: if (bmem_ready) cnt <= '0;
        RD_DATA: begin
          if (bmem_rvalid) begin
            rline[cnt] <= bmem_rdata;
            cnt        <= cnt + CNT_W'(1);
          end
        end
        WR: if (bmem_ready) cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // All bmem/dfp outputs depend on registered state only.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    dfp_resp   = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    case (state)
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      WR: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wline[cnt];
      end
      RESP:    dfp_resp = 1'b1;
      default: ;
    endcase
  end

  assign dfp_rdata = rline[BEATS-1:0];

endmodule

// File: tb/tb_cacheline_adapter.sv
module tb_cacheline_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance, default geometry (256/64)
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0, dfp_write = 1'b0;
  logic [255:0] dfp_wdata = '0;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b1;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  // 128/32 instance
  logic [31:0]  d1_addr = '0;
  logic         d1_read = 1'b0, d1_write = 1'b0;
  logic [127:0] d1_wdata = '0;
  logic [127:0] d1_rdata;
  logic         d1_resp;
  logic [31:0]  d1_baddr;
  logic         d1_bread, d1_bwrite;
  logic [31:0]  d1_bwdata;
  logic         d1_ready = 1'b1;
  logic [31:0]  d1_bdata = '0;
  logic         d1_rvalid = 1'b0;

  cacheline_adapter #(.LINE_WIDTH(128), .BUS_WIDTH(32), .ADDR_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst),
    .dfp_addr(d1_addr), .dfp_read(d1_read), .dfp_write(d1_write),
    .dfp_wdata(d1_wdata), .dfp_rdata(d1_rdata), .dfp_resp(d1_resp),
    .bmem_addr(d1_baddr), .bmem_read(d1_bread), .bmem_write(d1_bwrite),
    .bmem_wdata(d1_bwdata), .bmem_ready(d1_ready),
    .bmem_rdata(d1_bdata), .bmem_rvalid(d1_rvalid)
  );

  // 64/64 instance (single beat)
  logic [31:0] d2_addr = '0;
  logic        d2_read = 1'b0, d2_write = 1'b0;
  logic [63:0] d2_wdata = '0;
  logic [63:0] d2_rdata;
  logic        d2_resp;
  logic [31:0] d2_baddr;
  logic        d2_bread, d2_bwrite;
  logic [63:0] d2_bwdata;
  logic        d2_ready = 1'b1;
  logic [63:0] d2_bdata = '0;
  logic        d2_rvalid = 1'b0;

  cacheline_adapter #(.LINE_WIDTH(64), .BUS_WIDTH(64), .ADDR_WIDTH(32)) dut2 (
    .clk(clk), .rst(rst),
    .dfp_addr(d2_addr), .dfp_read(d2_read), .dfp_write(d2_write),
    .dfp_wdata(d2_wdata), .dfp_rdata(d2_rdata), .dfp_resp(d2_resp),
    .bmem_addr(d2_baddr), .bmem_read(d2_bread), .bmem_write(d2_bwrite),
    .bmem_wdata(d2_bwdata), .bmem_ready(d2_ready),
    .bmem_rdata(d2_bdata), .bmem_rvalid(d2_rvalid)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Transaction-level model of the main instance. A transaction is described
  // by its start cycle and its stall pattern; expected outputs for any cycle
  // follow from the latency rules by arithmetic on the relative cycle.
  int           tx_kind = 0;   // 0 none, 1 read, 2 write
  int           tx_t0 = 0;
  int           tx_rl = 0;     // read: cycles of bmem_ready=0 in request
  int           tx_gp = 4;     // read: beats delivered before the gap
  int           tx_g = 0;      // read: gap length
  int           tx_b = 0;      // write: beat index stalled
  int           tx_s = 0;      // write: stall length
  logic [31:0]  tx_addr_al = '0;
  logic [63:0]  tx_beats [4];
  logic [255:0] tx_line = '0;
  logic [255:0] last_line = '0;
  logic         chk_en = 1'b0;

  function automatic int wr_idx(input int i);
    if (i < tx_b) return i;
    if (i < tx_b + tx_s) return tx_b;
    return i - tx_s;
  endfunction

  int           rel, rresp;
  logic         e_rd, e_wr, e_resp, e_line_ok;
  logic [31:0]  e_addr;
  logic [63:0]  e_wd;
  logic [255:0] e_line;

  always @(negedge clk) begin
    if (chk_en) begin
      rel = cyc - tx_t0;
      e_rd = 1'b0; e_wr = 1'b0; e_resp = 1'b0; e_addr = '0; e_wd = '0;
      e_line_ok = 1'b1; e_line = last_line;
      if (tx_kind == 1) begin
        rresp  = 6 + tx_rl + tx_g;
        e_rd   = (rel >= 1) && (rel <= 1 + tx_rl);
        e_resp = (rel == rresp);
        if (e_rd) e_addr = tx_addr_al;
        if (rel < rresp) e_line_ok = 1'b0;
        else e_line = tx_line;
      end else if (tx_kind == 2) begin
        e_wr   = (rel >= 1) && (rel <= 4 + tx_s);
        e_resp = (rel == 5 + tx_s);
        if (e_wr) begin
          e_addr = tx_addr_al;
          e_wd   = tx_beats[wr_idx(rel - 1)];
        end
      end
      chk("bmem_read", bmem_read, e_rd);
      chk("bmem_write", bmem_write, e_wr);
      chk("dfp_resp", dfp_resp, e_resp);
      chk("bmem_addr", bmem_addr, e_addr);
      chk("bmem_wdata", bmem_wdata, e_wd);
      if (e_line_ok) chk("dfp_rdata", dfp_rdata, e_line);
    end
  end

  // Event monitor for the literal checks.
  int          rd_hi = 0, wr_hi = 0, resp_cnt = 0, resp_cyc = -1, hold66 = 0;
  logic [31:0] cap_addr = '0;
  logic [63:0] acc_q [$];

  always @(negedge clk) begin
    if (bmem_read) begin
      rd_hi = rd_hi + 1;
      cap_addr = bmem_addr;
    end
    if (bmem_write) begin
      wr_hi = wr_hi + 1;
      if (bmem_wdata == 64'h6666_6666_6666_6666) hold66 = hold66 + 1;
      if (bmem_ready) acc_q.push_back(bmem_wdata);
    end
    if (dfp_resp) begin
      resp_cnt = resp_cnt + 1;
      resp_cyc = cyc;
    end
  end

  task automatic idle(input int n, input logic spur);
    dfp_read = 1'b0; dfp_write = 1'b0; bmem_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      bmem_rvalid = spur;
      bmem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
  endtask

  task automatic run_read(input logic [31:0] a, input logic [63:0] b0, b1, b2, b3,
                          input int rl, gp, g, abort_at);
    int resp, j;
    if (tx_kind == 1) last_line = tx_line;
    tx_beats[0] = b0; tx_beats[1] = b1; tx_beats[2] = b2; tx_beats[3] = b3;
    tx_line = {b3, b2, b1, b0};
    tx_addr_al = a & ~32'h1F;
    tx_rl = rl; tx_gp = gp; tx_g = g; tx_t0 = cyc; tx_kind = 1;
    dfp_addr = a; dfp_read = 1'b1; dfp_write = 1'b0;
    resp = 6 + rl + g;
    for (int r = 0; r <= resp; r++) begin
      bmem_ready  = !(r >= 1 && r <= rl);
      bmem_rvalid = 1'b0;
      bmem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
      j = r - (2 + rl);
      if (j >= 0) begin
        if (j < gp) begin
          bmem_rvalid = 1'b1; bmem_rdata = tx_beats[j];
        end else if (j >= gp + g && j < 4 + g) begin
          bmem_rvalid = 1'b1; bmem_rdata = tx_beats[j - g];
        end
      end
      if (r == resp) dfp_read = 1'b0;
      if (r == abort_at) begin
        rst = 1'b1; bmem_rvalid = 1'b0;
      end
      @(posedge clk); #1;
      if (r == abort_at) begin
        rst = 1'b0; dfp_read = 1'b0; tx_kind = 0; last_line = '0;
        break;
      end
    end
    bmem_rvalid = 1'b0; bmem_ready = 1'b1;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [63:0] b0, b1, b2, b3,
                           input int b, s, input logic both);
    int resp, i;
    if (tx_kind == 1) last_line = tx_line;
    tx_beats[0] = b0; tx_beats[1] = b1; tx_beats[2] = b2; tx_beats[3] = b3;
    tx_addr_al = a & ~32'h1F;
    tx_b = b; tx_s = s; tx_t0 = cyc; tx_kind = 2;
    dfp_addr = a; dfp_write = 1'b1; dfp_read = both;
    dfp_wdata = {b3, b2, b1, b0};
    resp = 5 + s;
    for (int r = 0; r <= resp; r++) begin
      i = r - 1;
      bmem_ready = !(i >= b && i < b + s);
      if (r == resp) begin
        dfp_write = 1'b0; dfp_read = 1'b0;
      end
      @(posedge clk); #1;
    end
    bmem_ready = 1'b1;
  endtask

  localparam logic [63:0] LA = 64'hAAAA_AAAA_AAAA_AAAA, LB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] LC = 64'hCCCC_CCCC_CCCC_CCCC, LD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] L1 = 64'h1111_1111_1111_1111, L2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] L3 = 64'h3333_3333_3333_3333, L4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] L5 = 64'h5555_5555_5555_5555, L6 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] L7 = 64'h7777_7777_7777_7777, L8 = 64'h8888_8888_8888_8888;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s_rd, s_wr, s_acc, s_resp, s_h66, r1;
    logic [31:0] w1 [4];
    logic [31:0] rb1 [4];
    w1  = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    rb1 = '{32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004};

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 1'b0);

    // plain read, back-to-back beats
    s_rd = rd_hi;
    run_read(32'h101C, LA, LB, LC, LD, 0, 4, 0, -1);
    t = tx_t0;
    chk("t1_read_cycles", rd_hi - s_rd, 1);
    chk("t1_addr", cap_addr, 32'h1000);
    chk("t1_resp_cycle", resp_cyc - t, 6);
    chk("t1_line", dfp_rdata, {LD, LC, LB, LA});

    // spurious rvalid while idle, then stalled and gapped read
    idle(3, 1'b1);
    chk("t2_spurious_keep", dfp_rdata, {LD, LC, LB, LA});
    run_read(32'h1040, L1, L2, L3, L4, 2, 2, 3, -1);
    t = tx_t0;
    chk("t2_resp_cycle", resp_cyc - t, 11);
    chk("t2_line", dfp_rdata, {L4, L3, L2, L1});
    idle(1, 1'b0);

    // write, always ready
    s_acc = acc_q.size(); s_wr = wr_hi;
    run_write(32'h2000, L5, L6, L7, L8, 0, 0, 1'b0);
    t = tx_t0;
    chk("t3_beats", acc_q.size() - s_acc, 4);
    chk("t3_beat0", acc_q[s_acc], L5);
    chk("t3_beat1", acc_q[s_acc + 1], L6);
    chk("t3_beat2", acc_q[s_acc + 2], L7);
    chk("t3_beat3", acc_q[s_acc + 3], L8);
    chk("t3_wr_cycles", wr_hi - s_wr, 4);
    chk("t3_resp_cycle", resp_cyc - t, 5);
    idle(1, 1'b0);

    // write with two cycles of backpressure on beat 1
    s_acc = acc_q.size(); s_wr = wr_hi; s_h66 = hold66;
    run_write(32'h2040, L5, L6, L7, L8, 1, 2, 1'b0);
    t = tx_t0;
    chk("t4_hold66", hold66 - s_h66, 3);
    chk("t4_wr_cycles", wr_hi - s_wr, 6);
    chk("t4_resp_cycle", resp_cyc - t, 7);
    chk("t4_beats", acc_q.size() - s_acc, 4);
    chk("t4_beat1", acc_q[s_acc + 1], L6);
    chk("t4_beat2", acc_q[s_acc + 2], L7);
    idle(1, 1'b0);

    // read and write together: write wins
    s_rd = rd_hi;
    run_write(32'h3000, L8, L7, L6, L5, 0, 0, 1'b1);
    t = tx_t0;
    chk("t5_no_read", rd_hi - s_rd, 0);
    chk("t5_resp_cycle", resp_cyc - t, 5);
    idle(1, 1'b0);

    // reset after beat 2 of a read, then a normal read
    s_resp = resp_cnt;
    run_read(32'h1080, L1, L2, L3, L4, 0, 4, 0, 4);
    idle(3, 1'b0);
    chk("t6_no_resp", resp_cnt - s_resp, 0);
    chk("t6_rdata_cleared", dfp_rdata, 256'h0);
    chk("t6_addr_zero", bmem_addr, 32'h0);
    run_read(32'h10C0, LD, LC, LB, LA, 0, 4, 0, -1);
    t = tx_t0;
    chk("t6_resp_cycle", resp_cyc - t, 6);
    chk("t6_line", dfp_rdata, {LA, LB, LC, LD});
    idle(2, 1'b0);

    // 128/32 read
    d1_addr = 32'h4038; d1_read = 1'b1; r1 = -1;
    for (int r = 0; r < 10; r++) begin
      if (r == 1) begin
        chk("s1_bread", d1_bread, 1'b1);
        chk("s1_baddr", d1_baddr, 32'h4030);
      end
      if (d1_resp && r1 < 0) begin
        r1 = r; d1_read = 1'b0;
      end
      d1_rvalid = 1'b0;
      if (r >= 2 && r <= 5) begin
        d1_rvalid = 1'b1; d1_bdata = rb1[r - 2];
      end
      @(posedge clk); #1;
    end
    d1_read = 1'b0; d1_rvalid = 1'b0;
    chk("s1_resp_cycle", r1, 6);
    chk("s1_line", d1_rdata, 128'h40000004_30000003_20000002_10000001);

    // 128/32 write
    d1_addr = 32'h5005; d1_write = 1'b1; r1 = -1;
    d1_wdata = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    for (int r = 0; r < 10; r++) begin
      if (r >= 1 && r <= 4) begin
        chk("s1_bwrite", d1_bwrite, 1'b1);
        chk("s1_bwdata", d1_bwdata, w1[r - 1]);
      end
      if (r == 1) chk("s1_waddr", d1_baddr, 32'h5000);
      if (d1_resp && r1 < 0) begin
        r1 = r; d1_write = 1'b0;
      end
      @(posedge clk); #1;
    end
    d1_write = 1'b0;
    chk("s1_wresp_cycle", r1, 5);

    // 64/64 read
    d2_addr = 32'h300F; d2_read = 1'b1; r1 = -1;
    for (int r = 0; r < 8; r++) begin
      if (r == 1) begin
        chk("s2_bread", d2_bread, 1'b1);
        chk("s2_baddr", d2_baddr, 32'h3008);
      end
      if (d2_resp && r1 < 0) begin
        r1 = r; d2_read = 1'b0;
      end
      d2_rvalid = (r == 2);
      d2_bdata  = 64'hFEED_FACE_CAFE_BEEF;
      @(posedge clk); #1;
    end
    d2_read = 1'b0; d2_rvalid = 1'b0;
    chk("s2_resp_cycle", r1, 3);
    chk("s2_line", d2_rdata, 64'hFEED_FACE_CAFE_BEEF);

    // 64/64 write
    d2_addr = 32'h3017; d2_write = 1'b1; r1 = -1;
    d2_wdata = 64'h0123_4567_89AB_CDEF;
    for (int r = 0; r < 8; r++) begin
      if (r == 1) begin
        chk("s2_bwrite", d2_bwrite, 1'b1);
        chk("s2_bwdata", d2_bwdata, 64'h0123_4567_89AB_CDEF);
        chk("s2_waddr", d2_baddr, 32'h3010);
      end
      if (d2_resp && r1 < 0) begin
        r1 = r; d2_write = 1'b0;
      end
      @(posedge clk); #1;
    end
    d2_write = 1'b0;
    chk("s2_wresp_cycle", r1, 2);

    idle(2, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
